// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register: Status encoding and default width.
package shift_reg_pkg;

  localparam int SR_DEFAULT_N = 4;

  typedef enum logic [1:0] {
    SR_HOLD = 2'd0,
    SR_SHL  = 2'd1,
    SR_SHR  = 2'd2,
    SR_LOAD = 2'd3
  } sr_op_t;

endpackage

// File: rtl/shift_register_cell.sv
// One bit of the universal shift register: 4:1 operation mux feeding a DFF
// with synchronous active-low reset.
module shift_register_cell
  import shift_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] op_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       load_i,
  output logic       q_o
);

  logic q_q;
  logic q_d;

  // Nested ternaries keep an X on op_i visible as X on the next state.
  always_comb begin
    q_d = (op_i == SR_LOAD) ? load_i  :
          (op_i == SR_SHR)  ? right_i :
          (op_i == SR_SHL)  ? left_i  :
                              q_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/shift_register.sv
// N-bit universal shift register (hold / shift left / shift right / load).
// Define SHIFT_REG_SERIAL_OUT_EN to expose the serial taps SoL and SoR.
module shift_register
  import shift_reg_pkg::*;
#(
  parameter int           N           = SR_DEFAULT_N,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         Clock,
  input  logic         ResetN,
  input  logic [N-1:0] I,
  input  logic [1:0]   Status,
  input  logic         W,
  output logic [N-1:0] Q
`ifdef SHIFT_REG_SERIAL_OUT_EN
  ,
  output logic         SoL,
  output logic         SoR
`endif
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cell
      logic shl_src;
      logic shr_src;

      // Left shift moves bits toward the MSB, so each cell takes its lower neighbour.
      if (gi == 0) begin : g_shl_edge
        assign shl_src = W;
      end else begin : g_shl_inner
        assign shl_src = Q[gi-1];
      end

      if (gi == N - 1) begin : g_shr_edge
        assign shr_src = W;
      end else begin : g_shr_inner
        assign shr_src = Q[gi+1];
      end

      shift_register_cell #(
        .RESET_BIT(RESET_VALUE[gi])
      ) u_cell (
        .clk_i  (Clock),
        .rst_ni (ResetN),
        .op_i   (Status),
        .left_i (shl_src),
        .right_i(shr_src),
        .load_i (I[gi]),
        .q_o    (Q[gi])
      );
    end
  endgenerate

`ifdef SHIFT_REG_SERIAL_OUT_EN
  assign SoL = Q[N-1];
  assign SoR = Q[0];
`endif

endmodule

// File: tb/tb_shift_register.sv
// Scoreboard bench for shift_register: driver pushes model results, monitor pops
// and compares Q one negedge after the sampling edge.
module tb_shift_register;

  localparam int           N  = 4;
  localparam logic [N-1:0] RV = '0;

  logic         Clock;
  logic         ResetN;
  logic [N-1:0] I;
  logic [1:0]   Status;
  logic         W;
  logic [N-1:0] Q;
`ifdef SHIFT_REG_SERIAL_OUT_EN
  logic         SoL;
  logic         SoR;
`endif

  shift_register #(.N(N), .RESET_VALUE(RV)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .I     (I),
    .Status(Status),
    .W     (W),
    .Q     (Q)
`ifdef SHIFT_REG_SERIAL_OUT_EN
    ,
    .SoL   (SoL),
    .SoR   (SoR)
`endif
  );

  initial Clock = 1'b0;
  always #16 Clock = ~Clock;

  typedef struct {
    logic [N-1:0] q;
    string        tag;
    int           issue;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt = 0;
  int   checks   = 0;
  int   failures = 0;
  int   model_q  = 0;

  always @(posedge Clock) edge_cnt <= edge_cnt + 1;

  // Reference model: register contents as an integer in [0, 2**N).
  task automatic step(input logic rn, input logic [1:0] st, input logic [N-1:0] din,
                      input logic win, input string tag);
    @(negedge Clock);
    ResetN = rn;
    Status = st;
    I      = din;
    W      = win;
    if (!rn) begin
      model_q = int'(RV);
    end else begin
      case (st)
        2'd1:    model_q = (model_q * 2 + int'(win)) % (1 << N);
        2'd2:    model_q = model_q / 2 + int'(win) * (1 << (N - 1));
        2'd3:    model_q = int'(din);
        default: model_q = model_q;
      endcase
    end
    sb.push_back('{q: N'(model_q), tag: tag, issue: edge_cnt});
  endtask

  // Monitor: an entry becomes checkable once a rising edge has followed its issue.
  exp_t e;
  initial begin
    forever begin
      @(negedge Clock);
      while (sb.size() > 0 && sb[0].issue < edge_cnt) begin
        e = sb.pop_front();
        checks++;
        if (Q !== e.q) begin
          failures++;
          $display("FAIL %s: Q=%b expected %b", e.tag, Q, e.q);
        end else begin
          $display("txn %s: Q=%b ok", e.tag, Q);
        end
`ifdef SHIFT_REG_SERIAL_OUT_EN
        checks++;
        if (SoL !== e.q[N-1] || SoR !== e.q[0]) begin
          failures++;
          $display("FAIL %s_serial: SoL=%b SoR=%b expected SoL=%b SoR=%b",
                   e.tag, SoL, SoR, e.q[N-1], e.q[0]);
        end
`endif
      end
    end
  end

  initial begin
    ResetN = 1'b0;
    Status = 2'd0;
    I      = '0;
    W      = 1'b0;

    step(1'b0, 2'd0, 4'b0000, 1'b0, "reset");
    step(1'b1, 2'd3, 4'b1101, 1'b0, "load_1101");
    step(1'b1, 2'd3, 4'b0000, 1'b0, "load_0000");
    repeat (4) step(1'b1, 2'd1, 4'b0000, 1'b1, "shl_fill");
    step(1'b1, 2'd3, 4'b0000, 1'b0, "load_0000");
    repeat (4) step(1'b1, 2'd2, 4'b0000, 1'b1, "shr_fill");
    step(1'b1, 2'd3, 4'b1001, 1'b0, "load_1001");
    for (int k = 0; k < 4; k++)
      step(1'b1, 2'd0, N'($urandom_range(0, 15)), k[0], "hold");
    step(1'b1, 2'd3, 4'b1111, 1'b0, "load_1111");
    step(1'b0, 2'd3, 4'b0101, 1'b0, "reset_priority");
    step(1'b1, 2'd1, 4'b0000, 1'b1, "resume_shl");
    step(1'b1, 2'd3, 4'b1001, 1'b0, "serial_load");
    step(1'b1, 2'd1, 4'b0000, 1'b0, "serial_shl");

    for (int k = 0; k < 200; k++) begin
      step(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)),
           N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "random");
    end

    repeat (3) @(negedge Clock);
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
